sample_stream_engine: RTL and testbench
=======================================

Name: sample_stream_engine

Overview:
Parametrised multi-channel sample output stage sitting between the mixer and the DAC / mSGDMA streaming sink. It buffers interleaved mixed samples in an internal FIFO, applies backpressure to the generator, and releases one frame (CH samples) per sample-rate tick. Each frame drives the DAC input register and an Avalon-ST source with a real ready/valid handshake. It also counts underruns and late ticks for software monitoring.

Parameters:
DATA_W, 24, sample width in bits; multiple of 8
CH, 2, channels per frame; samples arrive interleaved ch0, ch1, ...
DEPTH, 16, FIFO depth in samples; power of 2, at least 2*CH
CLK_HZ, 100_000_000, clk frequency
FS_HZ, 96_000, output frame rate
OUT_W, 32, Avalon-ST data width; at least DATA_W

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
i_sample  in  DATA_W  signed mixed sample, interleaved by channel
i_valid  in  1  i_sample valid this cycle
o_ready  out  1  FIFO can accept; doubles as generator clk_en
i_swap_bytes  in  1  mode: byte-reverse samples on the ST output
i_mute  in  1  substitute zeros for output samples
o_dac_frame  out  CH*DATA_W  current frame for the DACs; ch0 in LSBs
aso_data  out  OUT_W  ST data, zero-extended sample
aso_channel  out  clog2(CH)  channel of the current beat
aso_valid  out  1  ST valid
aso_ready  in  1  ST ready
o_level  out  clog2(DEPTH)+1  FIFO occupancy
o_underrun_cnt  out  16  saturating count of ticks with level < CH
o_late_cnt  out  16  saturating count of ticks arriving while not IDLE

Behaviour:
- Reset (async, active-high): all outputs, counters and FIFO pointers are 0; FSM goes to IDLE; o_ready is 0 during reset.
- Write side:
  - A sample is written when i_valid && o_ready.
  - o_ready = (level < DEPTH), registered on the level after the write and pop of the same cycle.
  - A write attempted while full is ignored.
  - A simultaneous push and pop leaves level unchanged.
- Tick:
  - DIV = CLK_HZ/FS_HZ (integer division; 1041 for the defaults).
  - The counter runs 0..DIV-1 and pulses tick for one cycle at DIV-1.
  - The first tick occurs DIV cycles after reset release.
- FSM IDLE -> LOAD -> SEND -> IDLE:
  - IDLE, tick, level >= CH: go to LOAD with index 0.
  - IDLE, tick, level < CH: o_dac_frame becomes all zeros, o_underrun_cnt increments, no ST beats, stay in IDLE.
  - LOAD: pop one word per cycle into the frame slot at the index, for CH cycles. On the last pop, o_dac_frame updates atomically the next cycle, then go to SEND.
  - SEND: present channel index 0..CH-1, one beat each, with aso_valid held until aso_ready. The beat transfers on valid && ready, and the index advances. After the last transfer, go to IDLE.
  - aso_data and aso_channel are stable while valid && !ready.
  - A tick while in LOAD or SEND is dropped and o_late_cnt increments. FIFO contents are untouched; the frame is emitted at the next IDLE tick.
- Output formatting:
  - Mute zeroes both the DAC frame and the ST data, but the FIFO is still popped.
  - swap_bytes reverses the byte order within DATA_W for aso_data only.
  - aso_data upper bits are 0.
  - o_dac_frame is never byte-swapped.
- Counters saturate at 0xFFFF.
- Latency: tick to o_dac_frame update = CH+1 cycles; tick to first aso_valid = CH+1 cycles.
- Reset asserted mid-SEND: aso_valid drops immediately and the partial frame is discarded.

Decomposition:
- Package sse_pkg holds:
  - state enum {IDLE, LOAD, SEND};
  - function computing DIV;
  - clog2-based width constants;
  - byte-swap function.
- One sub-module, sample_fifo: synchronous FIFO parametrised by DATA_W and DEPTH, with push, pop, dout, level, full and empty. Reading it is first-word-fall-through (FWFT).

Test Plan:
- Bench parameters: CLK_HZ=1000, FS_HZ=100 (DIV=10), CH=2, DEPTH=8, DATA_W=24.
- Push 0x000011, 0x000022; wait for tick -> o_dac_frame=0x000022_000011 three cycles after tick; ST beats ch0=0x11 then ch1=0x22.
- Empty FIFO over 3 ticks -> o_underrun_cnt=3, o_dac_frame=0, no aso_valid.
- Push 9 samples with i_valid held -> o_ready falls after the 8th; the 9th is not written; o_level=8.
- Hold aso_ready=0 for 25 cycles after a frame -> o_late_cnt=2, aso_data stable, FIFO level unchanged by the missed ticks.
- i_swap_bytes=1, sample 0x123456 -> aso_data=0x00563412 while o_dac_frame slot=0x123456. i_mute=1 -> both zero, level decrements by 2.
- Assert reset during SEND -> aso_valid=0 asynchronously, counters 0, o_level=0.

Source files
------------

// File: rtl/sse_pkg.sv
// Shared types and helpers for the sample stream engine: FSM state, tick divider,
// width helpers and byte reversal.
package sse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } sse_state_t;

    // Widest sample the byte-swap helper handles.
    localparam int unsigned SWAP_MAX_W = 128;

    function automatic int unsigned sse_div(input int unsigned clk_hz, input int unsigned fs_hz);
        return clk_hz / fs_hz;
    endfunction

    function automatic int unsigned sse_idx_w(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic int unsigned sse_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned sse_lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                         input int unsigned nbytes);
        logic [SWAP_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < nbytes; i++) begin
            r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO; pushes while full and pops while
// empty are ignored.
module sample_fifo
    import sse_pkg::*;
#(
    parameter  int unsigned DATA_W = 24,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W  = sse_ptr_w(DEPTH),
    localparam int unsigned LVL_W  = sse_lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sample_stream_engine.sv
// Multi-channel output stage: buffers interleaved samples, releases one frame per
// sample-rate tick to the DAC register and an Avalon-ST source, counts underruns/late ticks.
module sample_stream_engine
    import sse_pkg::*;
#(
    parameter  int unsigned DATA_W = 24,
    parameter  int unsigned CH     = 2,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned CLK_HZ = 100_000_000,
    parameter  int unsigned FS_HZ  = 96_000,
    parameter  int unsigned OUT_W  = 32,
    localparam int unsigned IDX_W  = sse_idx_w(CH),
    localparam int unsigned LVL_W  = sse_lvl_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    i_sample,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_swap_bytes,
    input  logic                 i_mute,
    output logic [CH*DATA_W-1:0] o_dac_frame,
    output logic [OUT_W-1:0]     aso_data,
    output logic [IDX_W-1:0]     aso_channel,
    output logic                 aso_valid,
    input  logic                 aso_ready,
    output logic [LVL_W-1:0]     o_level,
    output logic [15:0]          o_underrun_cnt,
    output logic [15:0]          o_late_cnt
);

    localparam int unsigned DIV   = sse_div(CLK_HZ, FS_HZ);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]     r_div_cnt;
    logic                 w_tick;
    logic                 r_ready;
    sse_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_W-1:0]    r_load_buf [CH];
    logic [DATA_W-1:0]    r_st_buf [CH];
    logic [CH*DATA_W-1:0] r_dac_frame;
    logic [CH*DATA_W-1:0] w_next_frame;
    logic [15:0]          r_underrun;
    logic [15:0]          r_late;

    logic                 w_push;
    logic                 w_pop;
    logic [DATA_W-1:0]    w_fifo_dout;
    logic [LVL_W-1:0]     w_level;
    logic [LVL_W-1:0]     w_level_next;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_W-1:0]    w_pop_sample;
    logic [DATA_W-1:0]    w_st_sample;
    logic                 w_last_idx;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (i_sample),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_tick       = (r_div_cnt == CNT_W'(DIV - 1));
    assign w_push       = i_valid && r_ready && !w_full;
    assign w_pop        = (r_state == LOAD) && !w_empty;
    assign w_level_next = w_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_last_idx   = (r_idx == IDX_W'(CH - 1));

    // Mute and swap are applied as each word is popped so a frame in flight stays stable.
    assign w_pop_sample = i_mute ? '0 : w_fifo_dout;
    assign w_st_sample  = i_swap_bytes
                        ? DATA_W'(byte_swap(SWAP_MAX_W'(w_pop_sample), DATA_W / 8))
                        : w_pop_sample;

    always_comb begin
        w_next_frame = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            w_next_frame[c*DATA_W +: DATA_W] = (IDX_W'(c) == r_idx) ? w_pop_sample : r_load_buf[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + CNT_W'(1);
            r_ready   <= (w_level_next < LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            r_load_buf[r_idx] <= w_pop_sample;
            r_st_buf[r_idx]   <= w_st_sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_dac_frame <= '0;
            r_underrun  <= '0;
            r_late      <= '0;
        end else begin
            if (w_tick && (r_state != IDLE) && (r_late != '1)) begin
                r_late <= r_late + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        if (w_level >= LVL_W'(CH)) begin
                            r_state <= LOAD;
                            r_idx   <= '0;
                        end else begin
                            r_dac_frame <= '0;
                            if (r_underrun != '1) begin
                                r_underrun <= r_underrun + 16'd1;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (w_last_idx) begin
                        r_dac_frame <= w_next_frame;
                        r_state     <= SEND;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                SEND: begin
                    if (aso_ready) begin
                        if (w_last_idx) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready        = r_ready;
    assign o_dac_frame    = r_dac_frame;
    assign o_level        = w_level;
    assign o_underrun_cnt = r_underrun;
    assign o_late_cnt     = r_late;
    assign aso_valid      = (r_state == SEND);
    assign aso_channel    = aso_valid ? r_idx : '0;
    assign aso_data       = aso_valid ? OUT_W'(r_st_buf[r_idx]) : '0;

endmodule

// File: tb/tb_sample_stream_engine.sv
// Scenario bench for sample_stream_engine: ST beats are scoreboarded, frame/counter
// behaviour is checked inline per scenario.
`timescale 1ns/1ps
module tb_sample_stream_engine;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned CH     = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned FS_HZ  = 100;
    localparam int unsigned OUT_W  = 32;
    localparam int          DIV    = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [DATA_W-1:0]    i_sample = '0;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic                 i_swap_bytes = 1'b0;
    logic                 i_mute = 1'b0;
    logic [CH*DATA_W-1:0] o_dac_frame;
    logic [OUT_W-1:0]     aso_data;
    logic [0:0]           aso_channel;
    logic                 aso_valid;
    logic                 aso_ready = 1'b1;
    logic [3:0]           o_level;
    logic [15:0]          o_underrun_cnt;
    logic [15:0]          o_late_cnt;

    typedef struct packed {
        logic [0:0]       ch;
        logic [OUT_W-1:0] data;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    tb_cnt;

    sample_stream_engine #(
        .DATA_W (DATA_W),
        .CH     (CH),
        .DEPTH  (DEPTH),
        .CLK_HZ (CLK_HZ),
        .FS_HZ  (FS_HZ),
        .OUT_W  (OUT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sample       (i_sample),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_swap_bytes   (i_swap_bytes),
        .i_mute         (i_mute),
        .o_dac_frame    (o_dac_frame),
        .aso_data       (aso_data),
        .aso_channel    (aso_channel),
        .aso_valid      (aso_valid),
        .aso_ready      (aso_ready),
        .o_level        (o_level),
        .o_underrun_cnt (o_underrun_cnt),
        .o_late_cnt     (o_late_cnt)
    );

    always #5 clk = ~clk;

    // Reference tick phase: tick is active while tb_cnt == DIV-1.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Beat monitor: samples 1 ns before the transferring edge.
    always @(negedge clk) begin
        #4;
        if (!reset && aso_valid && aso_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got ch=%0d data=%h, expected no beat", aso_channel, aso_data);
            end else begin
                mon_e = sb.pop_front();
                if (aso_channel !== mon_e.ch || aso_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL beat: got ch=%0d data=%h, expected ch=%0d data=%h",
                             aso_channel, aso_data, mon_e.ch, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (tb_cnt != DIV - 1);
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        i_sample = v;
        i_valid  = 1'b1;
        step(1);
        i_valid  = 1'b0;
    endtask

    task automatic expect_beat(input logic [0:0] ch, input logic [OUT_W-1:0] d);
        beat_t b;
        b.ch   = ch;
        b.data = d;
        sb.push_back(b);
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if (o_ready !== 1'b0 || o_level !== 4'd0 || aso_valid !== 1'b0 || o_dac_frame !== '0 ||
            o_underrun_cnt !== 16'd0 || o_late_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b level=%0d valid=%b frame=%h und=%0d late=%0d, expected all 0",
                     o_ready, o_level, aso_valid, o_dac_frame, o_underrun_cnt, o_late_cnt);
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", o_ready);
        end
    endtask

    task automatic test_underrun();
        repeat (3) wait_tick();
        step(1);
        checks++;
        if (o_underrun_cnt !== 16'd3 || o_dac_frame !== '0 || aso_valid !== 1'b0) begin
            errors++;
            $display("FAIL underrun: got und=%0d frame=%h valid=%b, expected und=3 frame=0 valid=0",
                     o_underrun_cnt, o_dac_frame, aso_valid);
        end
    endtask

    task automatic test_basic();
        push(24'h000011);
        push(24'h000022);
        expect_beat(1'b0, 32'h00000011);
        expect_beat(1'b1, 32'h00000022);
        wait_tick();
        checks++;
        if (o_level !== 4'd2) begin
            errors++;
            $display("FAIL basic_level_at_tick: got %0d expected 2", o_level);
        end
        step(2);
        checks++;
        if (o_level !== 4'd1 || o_dac_frame !== '0 || aso_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_mid_load: got level=%0d frame=%h valid=%b, expected level=1 frame=0 valid=0",
                     o_level, o_dac_frame, aso_valid);
        end
        step(1);
        checks++;
        if (o_dac_frame !== 48'h000022_000011 || aso_valid !== 1'b1 || o_level !== 4'd0) begin
            errors++;
            $display("FAIL basic_frame: got frame=%h valid=%b level=%0d, expected frame=000022000011 valid=1 level=0",
                     o_dac_frame, aso_valid, o_level);
        end
        step(3);
        checks++;
        if (sb.size() != 0 || aso_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got pending=%0d valid=%b, expected pending=0 valid=0", sb.size(), aso_valid);
        end
    endtask

    task automatic test_full();
        logic exp_ready;
        wait_tick();
        step(1);
        checks++;
        if (o_dac_frame !== '0 || o_underrun_cnt !== 16'd4) begin
            errors++;
            $display("FAIL underrun_zero_frame: got frame=%h und=%0d, expected frame=0 und=4", o_dac_frame, o_underrun_cnt);
        end
        for (int k = 0; k < 9; k++) begin
            i_sample  = DATA_W'(k + 1);
            i_valid   = 1'b1;
            exp_ready = (k < 8);
            checks++;
            if (o_ready !== exp_ready) begin
                errors++;
                $display("FAIL full_ready[%0d]: got %b expected %b", k, o_ready, exp_ready);
            end
            if (exp_ready) expect_beat(1'(k % 2), OUT_W'(k + 1));
            step(1);
        end
        i_valid = 1'b0;
        checks++;
        if (o_level !== 4'd8 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: got level=%0d ready=%b, expected level=8 ready=0", o_level, o_ready);
        end
    endtask

    task automatic test_backpressure();
        step(5);
        aso_ready = 1'b0;
        wait_tick();
        step(3);
        checks++;
        if (o_dac_frame !== 48'h000004_000003) begin
            errors++;
            $display("FAIL bp_frame: got %h expected 000004000003", o_dac_frame);
        end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (aso_valid !== 1'b1 || aso_data !== 32'h00000003 || aso_channel !== 1'b0 || o_level !== 4'd4) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ch=%0d level=%0d, expected valid=1 data=00000003 ch=0 level=4",
                         k, aso_valid, aso_data, aso_channel, o_level);
            end
            step(1);
        end
        checks++;
        if (o_late_cnt !== 16'd2) begin
            errors++;
            $display("FAIL late_cnt: got %0d expected 2", o_late_cnt);
        end
        aso_ready = 1'b1;
    endtask

    task automatic test_format();
        bit drained = 1'b0;
        for (int n = 0; n < 200 && !drained; n++) begin
            if (sb.size() == 0 && o_level == 4'd0 && aso_valid == 1'b0) drained = 1'b1;
            else step(1);
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain_timeout: got pending=%0d level=%0d, expected 0 and 0", sb.size(), o_level);
        end
        wait_tick();
        step(1);
        i_swap_bytes = 1'b1;
        push(24'h123456);
        push(24'hABCDEF);
        expect_beat(1'b0, 32'h00563412);
        expect_beat(1'b1, 32'h00EFCDAB);
        wait_tick();
        step(3);
        checks++;
        if (o_dac_frame !== 48'hABCDEF_123456) begin
            errors++;
            $display("FAIL swap_dac_frame: got %h expected abcdef123456", o_dac_frame);
        end
        i_swap_bytes = 1'b0;
        i_mute       = 1'b1;
        push(24'h777777);
        push(24'h888888);
        expect_beat(1'b0, 32'h00000000);
        expect_beat(1'b1, 32'h00000000);
        wait_tick();
        checks++;
        if (o_level !== 4'd2 || o_dac_frame !== 48'hABCDEF_123456) begin
            errors++;
            $display("FAIL mute_before: got level=%0d frame=%h, expected level=2 frame=abcdef123456", o_level, o_dac_frame);
        end
        step(3);
        checks++;
        if (o_level !== 4'd0 || o_dac_frame !== '0 || aso_valid !== 1'b1) begin
            errors++;
            $display("FAIL mute_after: got level=%0d frame=%h valid=%b, expected level=0 frame=0 valid=1",
                     o_level, o_dac_frame, aso_valid);
        end
        i_mute = 1'b0;
        step(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL format_drain: got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_send();
        aso_ready = 1'b0;
        push(24'h0000AA);
        push(24'h0000BB);
        wait_tick();
        step(3);
        checks++;
        if (aso_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_send_entry: got valid=%b expected 1", aso_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (aso_valid !== 1'b0 || o_underrun_cnt !== 16'd0 || o_late_cnt !== 16'd0 || o_level !== 4'd0 ||
            o_dac_frame !== '0 || o_ready !== 1'b0 || aso_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b und=%0d late=%0d level=%0d frame=%h ready=%b data=%h, expected all 0",
                     aso_valid, o_underrun_cnt, o_late_cnt, o_level, o_dac_frame, o_ready, aso_data);
        end
        step(1);
        reset     = 1'b0;
        aso_ready = 1'b1;
        step(2);
        checks++;
        if (aso_valid !== 1'b0 || o_level !== 4'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got valid=%b level=%0d ready=%b, expected valid=0 level=0 ready=1",
                     aso_valid, o_level, o_ready);
        end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_basic();
        test_full();
        test_backpressure();
        test_format();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
